conv_result_writer: RTL and testbench

Sink for the convolution output stream. It captures the `data_o`/`valid_o` beats produced by the convolution top level into an internal output-feature-map buffer of (N-K_SIZE+1)^2 words, in raster order. It tracks frame progress and flags framing errors. It exposes a registered random-access read port so a host or downstream layer can fetch results after (or during) a frame.

---
 rtl/conv_result_writer.sv | 169 ++++++++++++++++
 tb/tb_conv_result_writer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_writer.sv
// conv_result_writer: captures the convolution result stream into a raster-ordered
//   buffer of OUT_DIM*OUT_DIM words and tracks frame progress and framing errors.
// Latency: a beat is stored on the accepting edge; read data arrives one cycle after rd_en.
// Backpressure: none; every valid_i beat in CAPTURE is stored, beats outside CAPTURE are dropped.
// Ports: clk/rst (sync, active-low); data_i/valid_i/running_i stream in; rd_en/rd_addr ->
//   rd_data/rd_valid read port; busy_o/done_o/wr_count_o/row_o/col_o progress;
//   overflow_o/short_o sticky framing flags.
module conv_result_writer #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int K_SIZE     = 3,
    parameter int RELU       = 0,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    input  logic                  running_i,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] wr_count_o,
    output logic [ADDR_WIDTH-1:0] row_o,
    output logic [ADDR_WIDTH-1:0] col_o,
    output logic                  overflow_o,
    output logic                  short_o
);

    localparam int OUT_DIM = N - K_SIZE + 1;
    localparam int DEPTH   = OUT_DIM * OUT_DIM;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_COL   = ADDR_WIDTH'(OUT_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A      = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    run_q, run_d;
    logic [ADDR_WIDTH-1:0]   wr_count_q, wr_count_d;
    logic [ADDR_WIDTH-1:0]   row_q, row_d;
    logic [ADDR_WIDTH-1:0]   col_q, col_d;
    logic                    overflow_q, overflow_d;
    logic                    short_q, short_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    start;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_word;

    assign start   = running_i & ~run_q;
    assign wr_word = ((RELU != 0) && data_i[DATA_WIDTH-1]) ? '0 : data_i;

    always_comb begin
        state_d    = state_q;
        run_d      = running_i;
        wr_count_d = wr_count_q;
        row_d      = row_q;
        col_d      = col_q;
        overflow_d = overflow_q;
        short_d    = short_q;
        wr_en      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A start coincident with a DONE beat wins: the beat is neither
                // stored nor counted as overflow, since the new frame clears flags.
                if (start) begin
                    state_d    = ST_CAPTURE;
                    wr_count_d = '0;
                    row_d      = '0;
                    col_d      = '0;
                    overflow_d = 1'b0;
                    short_d    = 1'b0;
                end else if ((state_q == ST_DONE) && valid_i) begin
                    overflow_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (valid_i) begin
                    wr_en      = 1'b1;
                    wr_count_d = wr_count_q + ONE_A;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + ONE_A;
                    end else begin
                        col_d = col_q + ONE_A;
                    end
                end
                // Completing the frame takes priority over the producer stopping.
                if (valid_i && (wr_count_q == LAST_WORD)) begin
                    state_d = ST_DONE;
                end else if (!running_i) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read port: out-of-range addresses return zero; contents hold when idle.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            if (rd_addr < DEPTH_A) begin
                rd_data_d = mem_q[rd_addr[IDX_W-1:0]];
            end else begin
                rd_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            run_q      <= 1'b0;
            wr_count_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            overflow_q <= 1'b0;
            short_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            wr_count_q <= wr_count_d;
            row_q      <= row_d;
            col_q      <= col_d;
            overflow_q <= overflow_d;
            short_q    <= short_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Buffer has no reset; the read above samples the old word, giving read-first.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_q[wr_count_q[IDX_W-1:0]] <= wr_word;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign busy_o     = (state_q == ST_CAPTURE);
    assign done_o     = (state_q == ST_DONE);
    assign wr_count_o = wr_count_q;
    assign row_o      = row_q;
    assign col_o      = col_q;
    assign overflow_o = overflow_q;
    assign short_o    = short_q;

endmodule

// File: tb/tb_conv_result_writer.sv
// tb_conv_result_writer: directed frames plus random traffic against a frame-level model.
// Two instances share stimulus: one with RELU=0, one with RELU=1.
// Outputs are compared every cycle on the falling edge.
module tb_conv_result_writer;

    localparam int N = 4, K = 3, DW = 16, AW = 14;
    localparam int OD = N - K + 1;
    localparam int DEPTH = OD * OD;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          running_i;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1;
    logic          busy0, busy1, done0, done1;
    logic [AW-1:0] wrc0, wrc1, row0, row1, col0, col1;
    logic          ovf0, ovf1, short0, short1;

    always #5 clk = ~clk;

    conv_result_writer #(.N(N), .DATA_WIDTH(DW), .K_SIZE(K), .RELU(0), .ADDR_WIDTH(AW)) u_dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .running_i(running_i),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .busy_o(busy0), .done_o(done0), .wr_count_o(wrc0), .row_o(row0), .col_o(col0),
        .overflow_o(ovf0), .short_o(short0)
    );

    conv_result_writer #(.N(N), .DATA_WIDTH(DW), .K_SIZE(K), .RELU(1), .ADDR_WIDTH(AW)) u_dut_relu (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .running_i(running_i),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .busy_o(busy1), .done_o(done1), .wr_count_o(wrc1), .row_o(row1), .col_o(col1),
        .overflow_o(ovf1), .short_o(short1)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame phase, word count and buffer images.
    typedef enum int { P_IDLE, P_CAPTURE, P_DONE } phase_t;
    phase_t        m_phase;
    int            m_count;
    bit            m_run, m_ovf, m_short, m_rd_valid, m_rd_chk;
    logic [DW-1:0] m_rd0, m_rd1;
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    bit            known [DEPTH];

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
        return ($signed(x) < 0) ? '0 : x;
    endfunction

    task automatic model_edge();
        bit start;
        if (!rst) begin
            m_phase = P_IDLE; m_count = 0; m_ovf = 0; m_short = 0;
            m_rd_valid = 0; m_rd0 = '0; m_rd1 = '0; m_rd_chk = 1; m_run = 0;
            return;
        end
        // read sees the buffer before this edge's write
        m_rd_valid = rd_en;
        if (rd_en) begin
            if (int'(rd_addr) >= DEPTH) begin
                m_rd0 = '0; m_rd1 = '0; m_rd_chk = 1;
            end else begin
                m_rd0 = mem0[rd_addr]; m_rd1 = mem1[rd_addr]; m_rd_chk = known[rd_addr];
            end
        end else begin
            m_rd_chk = 0;
        end
        start = running_i && !m_run;
        if (m_phase != P_CAPTURE) begin
            if (start) begin
                m_phase = P_CAPTURE; m_count = 0; m_ovf = 0; m_short = 0;
            end else if (m_phase == P_DONE && valid_i) begin
                m_ovf = 1;
            end
        end else begin
            if (valid_i) begin
                mem0[m_count] = data_i;
                mem1[m_count] = relu(data_i);
                known[m_count] = 1;
                m_count++;
            end
            if (m_count == DEPTH) m_phase = P_DONE;
            else if (!running_i) begin
                m_phase = P_IDLE; m_short = 1;
            end
        end
        m_run = running_i;
    endtask

    task automatic compare_all();
        chk("busy",   busy0,  m_phase == P_CAPTURE);
        chk("done",   done0,  m_phase == P_DONE);
        chk("wrcnt",  wrc0,   m_count);
        chk("row",    row0,   m_count / OD);
        chk("col",    col0,   m_count % OD);
        chk("ovf",    ovf0,   m_ovf);
        chk("short",  short0, m_short);
        chk("rdv",    rd_valid0, m_rd_valid);
        chk("r_busy", busy1,  m_phase == P_CAPTURE);
        chk("r_done", done1,  m_phase == P_DONE);
        chk("r_wrcnt", wrc1,  m_count);
        chk("r_ovf",  ovf1,   m_ovf);
        chk("r_short", short1, m_short);
        chk("r_rdv",  rd_valid1, m_rd_valid);
        if (m_rd_chk) begin
            chk("rdata",   rd_data0, m_rd0);
            chk("r_rdata", rd_data1, m_rd1);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic beat(input logic [DW-1:0] d);
        valid_i = 1'b1; data_i = d;
        cyc();
        valid_i = 1'b0;
    endtask

    task automatic rd(input int a);
        rd_en = 1'b1; rd_addr = AW'(a);
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic start_frame();
        running_i = 1'b0; cyc();
        running_i = 1'b1; cyc();
    endtask

    logic [DW-1:0] exp_a  [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    logic [DW-1:0] relu_i [4] = '{16'hFFF0, 16'h0005, 16'h8000, 16'h7FFF};
    logic [DW-1:0] relu_o [4] = '{16'h0000, 16'h0005, 16'h0000, 16'h7FFF};

    initial begin
        rst = 1'b0; data_i = '0; valid_i = 1'b0; running_i = 1'b0; rd_en = 1'b0; rd_addr = '0;
        cyc(); cyc();
        chk("rst_busy", busy0, 0);
        chk("rst_rdata", rd_data0, 0);
        rst = 1'b1;
        cyc();

        // basic frame with a gap between rows
        running_i = 1'b1; cyc();
        chk("start_busy", busy0, 1);
        beat(exp_a[0]); beat(exp_a[1]); cyc(); beat(exp_a[2]); beat(exp_a[3]);
        chk("frame_done", done0, 1);
        chk("frame_row", row0, OD);
        chk("frame_col", col0, 0);
        for (int i = 0; i < 4; i++) begin
            rd(i);
            chk("rd_basic", rd_data0, exp_a[i]);
            chk("rd_pulse", rd_valid0, 1);
        end
        cyc();
        chk("rd_pulse_end", rd_valid0, 0);

        // overflow leaves the buffer untouched
        beat(16'h1234);
        chk("ovf_set", ovf0, 1);
        rd(0);
        chk("ovf_addr0", rd_data0, 16'h0011);
        rd(4);
        chk("oor_data", rd_data0, 0);
        chk("oor_valid", rd_valid0, 1);

        // relu frame
        start_frame();
        chk("ovf_clear", ovf0, 0);
        for (int i = 0; i < 4; i++) beat(relu_i[i]);
        for (int i = 0; i < 4; i++) begin
            rd(i);
            chk("relu_on", rd_data1, relu_o[i]);
            chk("relu_off", rd_data0, relu_i[i]);
        end

        // read-first on a same-cycle read/write of the last word
        start_frame();
        beat(16'h0101); beat(16'h0202); beat(16'h0303);
        valid_i = 1'b1; data_i = 16'h0ABC; rd_en = 1'b1; rd_addr = AW'(3);
        cyc();
        valid_i = 1'b0; rd_en = 1'b0;
        chk("rf_old", rd_data0, 16'h7FFF);
        rd(3);
        chk("rf_new", rd_data0, 16'h0ABC);

        // short frame
        start_frame();
        beat(16'h0001); beat(16'h0002);
        running_i = 1'b0; cyc();
        chk("short_set", short0, 1);
        chk("short_cnt", wrc0, 2);
        chk("short_done", done0, 0);
        running_i = 1'b1; cyc();
        chk("short_clr", short0, 0);

        // reset mid-frame
        beat(16'h0003); beat(16'h0004);
        rst = 1'b0; running_i = 1'b0; cyc();
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_cnt", wrc0, 0);
        rst = 1'b1; cyc();

        // last beat coincident with running falling
        start_frame();
        beat(16'h0005); beat(16'h0006); beat(16'h0007);
        valid_i = 1'b1; data_i = 16'h0008; running_i = 1'b0;
        cyc();
        valid_i = 1'b0;
        chk("last_fall_done", done0, 1);
        chk("last_fall_short", short0, 0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 7) == 0) running_i = ~running_i;
            valid_i = 1'($urandom_range(0, 1));
            data_i  = 16'($urandom);
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = AW'($urandom_range(0, 5));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
